// File: rtl/rv_defs_pkg.sv
// Shared RV32I opcode, control-bundle and FSM-state definitions.
// Used by the multicycle controller and by the ALU control block.
package rv_defs;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] ALU_ADD   = 7'b0000011;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_REL = 2'd1;
    localparam logic [1:0] PC_ABS = 2'd2;

    typedef struct packed {
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [6:0] alu_op;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       is_halted;
    } ctrl_t;

    function automatic logic is_rv32i(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with
// memory-ready stalls and a retired-instruction counter.
module multicycle_control
    import rv_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [6:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             is_halted,
    output logic             illegal,
    output logic [CNT_W-1:0] num_inst
);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       illegal_q;
    logic       set_illegal;
    ctrl_t      c;

    logic is_ld, is_st, is_br, is_jal, is_jalr, is_lui;
    assign is_ld   = (opcode == OP_LOAD);
    assign is_st   = (opcode == OP_STORE);
    assign is_br   = (opcode == OP_BRANCH);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_lui  = (opcode == OP_LUI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            num_inst  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (c.pc_write)
                num_inst <= num_inst + CNT_W'(1);
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        c           = '0;
        c.alu_op    = ALU_ADD;
        state_nx    = state;
        set_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                c.mem_read = 1'b1;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    state_nx   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_nx = S_HALT;
                end else if (!is_rv32i(opcode)) begin
                    state_nx    = S_HALT;
                    set_illegal = 1'b1;
                end else if (is_lui || is_jal) begin
                    state_nx = S_WB;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                c.alu_op    = opcode;
                c.alu_src_a = (opcode == OP_AUIPC);
                c.alu_src_b = !(opcode == OP_REG || is_br);
                if (is_br) begin
                    c.pc_write = 1'b1;
                    c.pc_src   = bcond ? PC_REL : PC_SEQ;
                    state_nx   = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                c.i_or_d    = 1'b1;
                c.mem_write = is_st;
                c.mem_read  = !is_st;
                if (mem_ready) begin
                    if (is_st) begin
                        c.pc_write = 1'b1;
                        c.pc_src   = PC_SEQ;
                        state_nx   = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                c.reg_write = 1'b1;
                c.pc_write  = 1'b1;
                state_nx    = S_FETCH;
                unique case (1'b1)
                    is_ld:             c.mem_to_reg = WB_MDR;
                    is_jal || is_jalr: c.mem_to_reg = WB_PC4;
                    is_lui:            c.mem_to_reg = WB_IMM;
                    default:           c.mem_to_reg = WB_ALU;
                endcase
                unique case (1'b1)
                    is_jal:  c.pc_src = PC_REL;
                    is_jalr: c.pc_src = PC_ABS;
                    default: c.pc_src = PC_SEQ;
                endcase
            end
            S_HALT: begin
                c.is_halted = 1'b1;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
        // Reset must silence every strobe combinationally, not at the next edge.
        if (reset) begin
            c           = '0;
            c.alu_op    = ALU_ADD;
            state_nx    = S_FETCH;
            set_illegal = 1'b0;
        end
    end

    assign ir_write   = c.ir_write;
    assign i_or_d     = c.i_or_d;
    assign mem_read   = c.mem_read;
    assign mem_write  = c.mem_write;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign alu_op     = c.alu_op;
    assign reg_write  = c.reg_write;
    assign mem_to_reg = c.mem_to_reg;
    assign pc_write   = c.pc_write;
    assign pc_src     = c.pc_src;
    assign is_halted  = c.is_halted;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces
// built from the instruction-class rules, compared every cycle.
module tb_multicycle_control;

    localparam logic [6:0] T_LUI  = 7'b0110111;
    localparam logic [6:0] T_AUI  = 7'b0010111;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111;
    localparam logic [6:0] T_BR   = 7'b1100011;
    localparam logic [6:0] T_LD   = 7'b0000011;
    localparam logic [6:0] T_ST   = 7'b0100011;
    localparam logic [6:0] T_IMM  = 7'b0010011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_FEN  = 7'b0001111;
    localparam logic [6:0] T_SYS  = 7'b1110011;

    typedef struct packed {
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [6:0] alu_op;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       is_halted;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t       e;
        logic [6:0] op;
        logic       mr;
        logic       bc;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = '0;
    logic       bcond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, i_or_d, mem_read, mem_write;
    logic       alu_src_a, alu_src_b, reg_write, pc_write;
    logic       is_halted, illegal;
    logic [6:0] alu_op;
    logic [1:0] mem_to_reg, pc_src;
    logic [3:0] num_inst;

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .mem_ready(mem_ready), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_src(pc_src), .is_halted(is_halted),
        .illegal(illegal), .num_inst(num_inst)
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {ir_write, i_or_d, mem_read, mem_write, alu_src_a,
                  alu_src_b, alu_op, reg_write, mem_to_reg, pc_write,
                  pc_src, is_halted, illegal};

    int   checks = 0;
    int   failures = 0;
    int   cycles = 0;
    logic [3:0] cnt = '0;
    bit   halted;
    cyc_t q[$];
    ctl_t obs[$];

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.alu_op = 7'b0000011;
        return c;
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op inside {T_LUI, T_AUI, T_JAL, T_JALR, T_BR, T_LD,
                          T_ST, T_IMM, T_R, T_FEN, T_SYS};
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", n, cycles, a, e);
        end
    endtask

    task automatic chk_ctl(input string n, input ctl_t e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d op=%b act=%h exp=%h",
                     n, cycles, opcode, act, e);
        end
    endtask

    task automatic push(input ctl_t c, input logic [6:0] op,
                        input logic mr, input logic bc);
        cyc_t x;
        x.e  = c;
        x.op = op;
        x.mr = mr;
        x.bc = bc;
        q.push_back(x);
    endtask

    // Expected trace of one instruction from its class and stall lengths.
    task automatic build(input logic [6:0] op, input int fs, input int ms,
                         input logic bc);
        ctl_t c;
        bit   ld, st;
        ld = (op == T_LD);
        st = (op == T_ST);
        for (int i = 0; i < fs; i++) begin
            c = idle(); c.mem_read = 1;
            push(c, op, 1'b0, 1'($urandom));
        end
        c = idle(); c.mem_read = 1; c.ir_write = 1;
        push(c, op, 1'b1, 1'($urandom));
        push(idle(), op, 1'($urandom), 1'($urandom));
        if (op == T_SYS || !legal(op)) begin
            for (int i = 0; i < 20; i++) begin
                c = idle(); c.is_halted = 1; c.illegal = !legal(op);
                push(c, op, 1'($urandom), 1'($urandom));
            end
            halted = 1;
            return;
        end
        if (op != T_LUI && op != T_JAL) begin
            c = idle();
            c.alu_op = op;
            c.alu_src_a = (op == T_AUI);
            c.alu_src_b = !(op == T_R || op == T_BR);
            if (op == T_BR) begin
                c.pc_write = 1;
                c.pc_src = bc ? 2'd1 : 2'd0;
                push(c, op, 1'($urandom), bc);
                return;
            end
            push(c, op, 1'($urandom), 1'($urandom));
            if (ld || st) begin
                c = idle(); c.i_or_d = 1; c.mem_read = ld; c.mem_write = st;
                for (int i = 0; i < ms; i++)
                    push(c, op, 1'b0, 1'($urandom));
                if (st) begin
                    c.pc_write = 1;
                    push(c, op, 1'b1, 1'($urandom));
                    return;
                end
                push(c, op, 1'b1, 1'($urandom));
            end
        end
        c = idle(); c.reg_write = 1; c.pc_write = 1;
        c.mem_to_reg = ld ? 2'd1 : (op == T_JAL || op == T_JALR) ? 2'd2 :
                       (op == T_LUI) ? 2'd3 : 2'd0;
        c.pc_src = (op == T_JAL) ? 2'd1 : (op == T_JALR) ? 2'd2 : 2'd0;
        push(c, op, 1'($urandom), 1'($urandom));
    endtask

    task automatic run_n(input int n);
        cyc_t x;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            x = q.pop_front();
            opcode = x.op;
            mem_ready = x.mr;
            bcond = x.bc;
            #1;
            chk_ctl("ctl", x.e);
            chk("num_inst", 32'(num_inst), 32'(cnt));
            obs.push_back(act);
            if (x.e.pc_write) cnt = cnt + 4'd1;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run();
        run_n(q.size());
    endtask

    task automatic do_reset();
        reset = 1;
        mem_ready = 0;
        #1;
        chk_ctl("reset_out", idle());
        chk("reset_cnt", 32'(num_inst), 0);
        cnt = '0;
        halted = 0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        obs.delete();
    endtask

    function automatic int count_rw();
        int n = 0;
        foreach (obs[i]) n += int'(obs[i].reg_write);
        return n;
    endfunction

    function automatic int count_pw();
        int n = 0;
        foreach (obs[i]) n += int'(obs[i].pc_write);
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] tab [10];
        logic [6:0] op;
        int n, k;
        tab = '{T_LUI, T_AUI, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_IMM,
                T_R, T_FEN};
        #2;
        do_reset();

        build(T_R, 0, 0, 0);
        run();
        chk("add_len", obs.size(), 4);
        chk("add_irw", 32'(obs[0].ir_write), 1);
        chk("add_rw_c4", 32'(obs[3].reg_write), 1);
        chk("add_rw_cnt", count_rw(), 1);
        chk("add_op", 32'(obs[2].alu_op), 32'h33);
        chk("add_ninst", 32'(num_inst), 1);

        obs.delete();
        build(T_LD, 1, 3, 0);
        run();
        n = 0;
        foreach (obs[i]) n += int'(obs[i].mem_read && obs[i].i_or_d);
        chk("lw_memrd", n, 4);
        chk("lw_m2r", 32'(obs[obs.size()-1].mem_to_reg), 1);
        chk("lw_ninst", 32'(num_inst), 2);

        obs.delete();
        build(T_BR, 0, 0, 1);
        build(T_BR, 0, 0, 0);
        run();
        chk("br_pw", count_pw(), 2);
        chk("br_rw", count_rw(), 0);
        chk("br_src1", 32'(obs[2].pc_src), 1);
        chk("br_src0", 32'(obs[5].pc_src), 0);

        obs.delete();
        build(T_JALR, 0, 0, 0);
        run();
        chk("jalr_m2r", 32'(obs[obs.size()-1].mem_to_reg), 2);
        chk("jalr_src", 32'(obs[obs.size()-1].pc_src), 2);

        obs.delete();
        build(7'b1111111, 0, 0, 0);
        run();
        chk("ill_halt", 32'(is_halted), 1);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_pw", count_pw(), 0);
        chk("ill_ninst", 32'(num_inst), 5);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            build(T_IMM, 0, 0, 0);
            run();
        end
        chk("wrap15", 32'(num_inst), 15);
        build(T_R, 0, 0, 0);
        run();
        chk("wrap0", 32'(num_inst), 0);

        do_reset();
        build(T_R, 0, 0, 0);
        build(T_R, 0, 0, 0);
        run();
        build(T_ST, 0, 5, 0);
        run_n(5);
        opcode = T_ST;
        mem_ready = 0;
        #1;
        chk("sw_stall_wr", 32'(mem_write), 1);
        chk("sw_pre_cnt", 32'(num_inst), 2);
        #2;
        reset = 1;
        #1;
        chk("sw_rst_wr", 32'(mem_write), 0);
        chk_ctl("sw_rst_ctl", idle());
        chk("sw_rst_cnt", 32'(num_inst), 0);
        q.delete();
        cnt = '0;
        @(negedge clk);
        reset = 0;
        obs.delete();
        build(T_LUI, 0, 0, 0);
        run();
        chk("post_rst_fetch", 32'(obs[0].mem_read), 1);

        for (int s = 0; s < 40; s++) begin
            do_reset();
            n = $urandom_range(1, 25);
            for (int i = 0; i < n && !halted; i++) begin
                k = $urandom_range(0, 59);
                if (k == 0)      op = T_SYS;
                else if (k == 1) op = 7'($urandom);
                else             op = tab[$urandom_range(0, 9)];
                build(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
                run();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7  instruction[6:0] from IR; stable from DECODE onward.
REQ-005 bcond  in  1  branch-taken result from ALU; valid in EXEC.
REQ-006 mem_ready  in  1  memory completes current read/write this cycle.
REQ-007 ir_write  out  1  load IR from memory read data.
REQ-008 i_or_d  out  1  memory address: 0=PC, 1=ALUOut.
REQ-009 mem_read / mem_write  out  1 each  memory strobes.
REQ-010 alu_src_a  out  1  0=rs1, 1=PC; alu_src_b  out  1  0=rs2, 1=imm.
REQ-011 alu_op  out  7  opcode forwarded to ALU control in EXEC; 7'b0000011 (add) otherwise.
REQ-012 reg_write  out  1; mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC+4, 3=imm.
REQ-013 pc_write  out  1; pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALUOut&~1.
REQ-014 is_halted  out  1; illegal  out  1; num_inst  out  CNT_W  retired count.

Function
REQ-015 States: FETCH, DECODE, EXEC, MEM, WB, HALT; one-hot or binary, registered.
REQ-016 FETCH: mem_read=1, i_or_d=0; stall while mem_ready=0; when mem_ready=1, ir_write=1 for that cycle, next DECODE.
REQ-017 DECODE: ECALL (1110011) -> HALT; LUI, JAL -> WB; any opcode outside RV32I base set -> HALT with illegal=1; else -> EXEC.
REQ-018 EXEC: alu_src_a=1 for AUIPC else 0; alu_src_b=0 for R-type and branch, else 1.
REQ-019 EXEC branch: pc_write=1, pc_src=1 if bcond else 0, next FETCH (branch = 3 cycles plus fetch stall).
REQ-020 EXEC load/store -> MEM; R, I, AUIPC, JALR -> WB.
REQ-021 MEM: i_or_d=1; load asserts mem_read, store asserts mem_write; hold state and strobe while mem_ready=0.
REQ-022 MEM completion: load -> WB; store -> FETCH with pc_write=1, pc_src=0.
REQ-023 WB: reg_write=1, pc_write=1 for one cycle, then FETCH.
REQ-024 WB mem_to_reg: load 1, JAL/JALR 2, LUI 3, else 0; pc_src: JAL 1, JALR 2, else 0.
REQ-025 num_inst increments by 1 on every cycle pc_write=1; wraps modulo 2^CNT_W.
REQ-026 HALT: absorbing until reset; is_halted=1; all write/strobe outputs 0; num_inst frozen.
REQ-027 Controls are pure functions of state, opcode, bcond, mem_ready; no output asserted outside listed states.
REQ-028 mem_read and mem_write never asserted together; reg_write and ir_write never asserted together.

Reset
REQ-029 reset=1 forces FETCH immediately, regardless of clk, including mid-stall in FETCH/MEM.
REQ-030 During reset all outputs 0 except alu_op=7'b0000011; num_inst=0; illegal=0; is_halted=0.
REQ-031 First fetch begins on the first rising clk edge after reset deasserts.

Structure
REQ-032 Opcode constants and state encoding SHALL live in a shared rv_defs package also used by the ALU control block.
REQ-033 No sub-module; single always_ff for state/counter, one combinational block for next state and outputs.

Verification
REQ-034 ADD x3,x1,x2 with mem_ready tied 1 -> FETCH,DECODE,EXEC,WB; reg_write in cycle 4; num_inst=1.
REQ-035 LW with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, i_or_d=1, then WB with mem_to_reg=1.
REQ-036 BEQ with bcond=1 then bcond=0 -> pc_src=1 then 0, pc_write once each, reg_write never.
REQ-037 Opcode 7'b1111111 -> HALT, illegal=1, is_halted=1; no further pc_write over 20 cycles.
REQ-038 reset pulsed asynchronously mid-MEM stall of SW -> mem_write drops same time step, state FETCH, num_inst=0.
REQ-039 JALR -> WB with mem_to_reg=2, pc_src=2; counter with CNT_W=4 wraps 15->0 after 16th instruction.
